// File: rtl/cache_miss_handler_pkg.sv
// -----------------------------------------------------------------------------
// cache_miss_handler_pkg
// Shared definitions for the cache miss handler slice.
//   - Default geometry that matches the cache parameter header:
//     ways, tag width, set-index width and performance counter width.
//   - Miss-handling FSM state encoding.
// -----------------------------------------------------------------------------
package cache_miss_handler_pkg;

    localparam int DOSA_DEF    = 4;
    localparam int TAG_CNT_DEF = 16;
    localparam int SET_W_DEF   = 6;
    localparam int CNT_W_DEF   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } miss_state_t;

endpackage

// File: rtl/rr_victim_table.sv
// -----------------------------------------------------------------------------
// rr_victim_table
// Per-set round-robin victim pointers. There is one pointer per set, and
// each pointer cycles 0 .. DOSA-1.
// Ports:
//   clk, RST          clock, asynchronous active-high reset (clears all pointers)
//   rd_set / rd_way   combinational read of the pointer for a set
//   inc_en / inc_set  advance the pointer of inc_set by one (wraps to 0)
// -----------------------------------------------------------------------------
module rr_victim_table
    import cache_miss_handler_pkg::*;
#(
    parameter int DOSA  = DOSA_DEF,
    parameter int SET_W = SET_W_DEF,
    parameter int ENC_W = $clog2(DOSA)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [SET_W-1:0] rd_set,
    output logic [ENC_W-1:0] rd_way,
    input  logic             inc_en,
    input  logic [SET_W-1:0] inc_set
);

    localparam int SETS = 1 << SET_W;
    localparam logic [ENC_W-1:0] LAST_WAY = ENC_W'(DOSA - 1);

    logic [ENC_W-1:0] rr_ptr [SETS];

    // The wrap is explicit so that non-power-of-two way counts also cycle
    // through exactly DOSA ways.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < SETS; i++) begin
                rr_ptr[i] <= '0;
            end
        end else if (inc_en) begin
            if (rr_ptr[inc_set] == LAST_WAY) begin
                rr_ptr[inc_set] <= '0;
            end else begin
                rr_ptr[inc_set] <= rr_ptr[inc_set] + ENC_W'(1);
            end
        end
    end

    assign rd_way = rr_ptr[rd_set];

endmodule

// File: rtl/cache_miss_handler.sv
// -----------------------------------------------------------------------------
// cache_miss_handler
// Handles cache misses one at a time. A miss reported by the tag-compare stage
// is captured together with its round-robin victim way. The handler then
// issues a refill request and waits for the refill response. Finally it writes
// the new tag into the victim way. The upstream pipeline is stalled while a
// miss is outstanding. Hits and completed misses are counted in saturating
// counters.
// Ports:
//   clk, RST                  clock, asynchronous active-high reset
//   peEN_3, HIT, hit_encode   lookup result (valid, hit flag, hit way)
//   Tag_in, Set_in            lookup tag and set, aligned with peEN_3
//   stall                     upstream hold (any state other than IDLE)
//   mem_req_valid/ready/addr  refill request handshake, addr = {tag, set}
//   mem_rsp_valid             refill data returned (single-cycle pulse)
//   tag_we, tag_wr_*          tag-array write port, {valid, tag} data
//   hit_cnt, miss_cnt         saturating performance counters
// -----------------------------------------------------------------------------
module cache_miss_handler
    import cache_miss_handler_pkg::*;
#(
    parameter int DOSA    = DOSA_DEF,
    parameter int TAG_CNT = TAG_CNT_DEF,
    parameter int SET_W   = SET_W_DEF,
    parameter int ENC_W   = $clog2(DOSA),
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     peEN_3,
    input  logic                     HIT,
    input  logic [ENC_W-1:0]         hit_encode,
    input  logic [TAG_CNT-1:0]       Tag_in,
    input  logic [SET_W-1:0]         Set_in,
    output logic                     stall,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [TAG_CNT+SET_W-1:0] mem_req_addr,
    input  logic                     mem_rsp_valid,
    output logic                     tag_we,
    output logic [SET_W-1:0]         tag_wr_set,
    output logic [ENC_W-1:0]         tag_wr_way,
    output logic [TAG_CNT:0]         tag_wr_data,
    output logic [CNT_W-1:0]         hit_cnt,
    output logic [CNT_W-1:0]         miss_cnt
);

    miss_state_t state, state_nxt;

    logic [TAG_CNT-1:0] lat_tag;
    logic [SET_W-1:0]   lat_set;
    logic [ENC_W-1:0]   lat_way;
    logic [ENC_W-1:0]   victim_way;

    logic lookup_hit;
    logic lookup_miss;
    logic fill;

    // The hit way is not needed to handle a miss. This sink keeps the port
    // visible to lint as consumed.
    logic unused_hit_encode;
    assign unused_hit_encode = ^hit_encode;

    // Lookups are only accepted in IDLE. While stalled, the upstream stage
    // is holding and any peEN_3 it presents is not a new lookup.
    assign lookup_hit  = (state == IDLE) && peEN_3 &&  HIT;
    assign lookup_miss = (state == IDLE) && peEN_3 && !HIT;
    assign fill        = (state == FILL);
    assign stall       = (state != IDLE);

    rr_victim_table #(
        .DOSA  (DOSA),
        .SET_W (SET_W),
        .ENC_W (ENC_W)
    ) u_rr_victim_table (
        .clk     (clk),
        .RST     (RST),
        .rd_set  (Set_in),
        .rd_way  (victim_way),
        .inc_en  (fill),
        .inc_set (lat_set)
    );

    // State register plus the miss context captured at the moment of the
    // miss. The refill address is taken from this context, so it holds
    // steady during backpressure.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            lat_tag <= '0;
            lat_set <= '0;
            lat_way <= '0;
        end else begin
            state <= state_nxt;
            if (lookup_miss) begin
                lat_tag <= Tag_in;
                lat_set <= Set_in;
                lat_way <= victim_way;
            end
        end
    end

    // Next-state logic and handshake/write strobes. The response is only
    // honoured in WAIT. A pulse that arrives in another state (for example,
    // the late answer to a refill aborted by reset) falls through the
    // default and is dropped.
    always_comb begin
        state_nxt     = state;
        mem_req_valid = 1'b0;
        tag_we        = 1'b0;
        tag_wr_set    = '0;
        tag_wr_way    = '0;
        tag_wr_data   = '0;
        case (state)
            IDLE: begin
                if (lookup_miss) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                tag_we      = 1'b1;
                tag_wr_set  = lat_set;
                tag_wr_way  = lat_way;
                tag_wr_data = {1'b1, lat_tag};
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_req_addr = {lat_tag, lat_set};

    // Performance counters stop at all-ones instead of wrapping. A wrap
    // would make a long run look like very few events.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (lookup_hit && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
            if (fill && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

endmodule
